// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake bundle for the fetch queue
interface fetch_queue_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
);
  logic               flush;
  logic               ihit;
  logic [PC_W-1:0]    npc_in;
  logic [INSTR_W-1:0] imemload_in;
  logic               dec_pause;
  logic               fq_ready;
  logic               out_valid;
  logic [PC_W-1:0]    npc_out;
  logic [INSTR_W-1:0] imemload_out;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               ovf;
  modport master (
    output flush, ihit, npc_in, imemload_in, dec_pause,
    input  fq_ready, out_valid, npc_out, imemload_out, count, full, ovf
  );
  modport slave (
    input  flush, ihit, npc_in, imemload_in, dec_pause,
    output fq_ready, out_valid, npc_out, imemload_out, count, full, ovf
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {next-PC, instruction} between fetch and decode
module fetch_queue #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input logic          CLK,
  input logic          RST,
  fetch_queue_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  logic [PC_W+INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf_r, push, pop;
  assign fq.out_valid    = cnt != '0;
  assign fq.full         = cnt == CNT_W'(DEPTH);
  assign fq.fq_ready     = !fq.full || (fq.out_valid && !fq.dec_pause);
  assign fq.count        = cnt;
  assign fq.ovf          = ovf_r;
  assign pop             = fq.out_valid && !fq.dec_pause && !fq.flush;
  assign push            = fq.ihit && fq.fq_ready && !fq.flush;
  assign {fq.npc_out, fq.imemload_out} = fq.out_valid ? mem[rd_ptr] : '0;
  // storage write; contents need no reset since empty slots are masked on output
  always_ff @(posedge CLK)
    if (push && !RST) mem[wr_ptr] <= {fq.npc_in, fq.imemload_in};
  // pointers, occupancy and sticky overflow; reset and flush both empty the queue
  always_ff @(posedge CLK)
    if (RST || fq.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (fq.ihit && !fq.fq_ready) ovf_r <= 1'b1;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch-to-decode buffer that replaces the single-entry IF/ID latch with a DEPTH-entry FIFO of {next-PC, instruction} pairs. It sits between the instruction-fetch stage and decode. Fetch pushes on every instruction hit, and decode pops when it is not paused. A flush empties the queue in one cycle, and decode sees an all-zero bubble whenever the queue is empty.

## Interface
- PC_W, 32, width of the next-PC field
- INSTR_W, 32, width of the instruction field
- DEPTH, 4, number of entries; power of two, at least 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; synchronous, active-high
- flush  in  1  discard all entries, including any push in the same cycle
- ihit  in  1  push request; fetch has a valid instruction this cycle
- npc_in  in  PC_W  next PC accompanying the pushed instruction
- imemload_in  in  INSTR_W  instruction word to push
- dec_pause  in  1  decode is stalled; the head entry is held and not popped
- fq_ready  out  1  queue can accept a push this cycle (combinational)
- out_valid  out  1  head entry is valid
- npc_out  out  PC_W  head next PC; 0 when empty
- imemload_out  out  INSTR_W  head instruction; 0 when empty (bubble)
- count  out  CNT_W  current occupancy
- full  out  1  count == DEPTH
- ovf  out  1  sticky flag: a push was attempted while fq_ready=0

## Operation
- State:
  - storage array of DEPTH entries, each {PC_W + INSTR_W} bits
  - read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH
  - registered count, registered ovf
- Control terms:
  - pop = out_valid && !dec_pause && !flush
  - push = ihit && fq_ready && !flush
  - fq_ready = !full || (out_valid && !dec_pause); a full queue accepts a push in the same cycle as a pop.
- Priority on each edge: RST > flush > normal operation.
  - RST: rd_ptr=0, wr_ptr=0, count=0, ovf=0. Storage contents are don't-care.
  - flush: rd_ptr=0, wr_ptr=0, count=0, ovf=0. Any push or pop requested in the same cycle is ignored.
  - Normal operation:
    - push: write {npc_in, imemload_in} at wr_ptr, then wr_ptr+1
    - pop: rd_ptr+1
    - count: +1 for push only, -1 for pop only, unchanged for both or neither
- Dropped pushes: ihit && !fq_ready && !flush drops the push and sets ovf. ovf stays set until RST or flush.
- Outputs:
  - out_valid = (count != 0)
  - npc_out and imemload_out show storage[rd_ptr] when out_valid=1; otherwise they are forced to 0.
  - All outputs decode directly from registered state, except fq_ready, which also depends on dec_pause.
- Empty queue: a push and pop in the same cycle is impossible, because pop requires out_valid. There is no combinational bypass from input to output.

## Timing
- Reset values: out_valid=0, npc_out=0, imemload_out=0, count=0, full=0, ovf=0, fq_ready=1.
- Latency: ihit at cycle N into an empty queue makes out_valid=1 with that entry at cycle N+1.
- Throughput: one push and one pop per cycle sustained. Count stays constant when pushing and popping every cycle.
- Flush: flush at cycle N gives out_valid=0, count=0 and outputs 0 at cycle N+1.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no gap; ordering is strictly FIFO across the wrap.
- Full with dec_pause=1: fq_ready=0 in the same cycle, and an ihit then sets ovf at the next edge.
- Full with dec_pause=0 and out_valid=1: fq_ready=1, the push is accepted, and count stays at DEPTH.
- RST mid-operation: all outputs return to their reset values at the next edge, regardless of flush, ihit or dec_pause.

## Test plan
- Reset and empty: assert RST for 2 cycles, then drive ihit=0. Outputs stay 0, count=0, fq_ready=1, ovf=0.
- Fill and drain:
  - With dec_pause=1, push pairs (0x4,0xA1), (0x8,0xA2), (0xC,0xA3), (0x10,0xA4). full=1, count=4, head=(0x4,0xA1).
  - Release dec_pause. Heads then appear in order 0xA1..0xA4 on consecutive cycles, followed by out_valid=0 and outputs 0.
- Full, simultaneous push/pop: with the queue full and dec_pause=0, push (0x14,0xA5). count stays 4, head advances to 0xA2, ovf=0. Repeat 8 times to cover pointer wrap with order preserved.
- Overflow: with the queue full and dec_pause=1, push (0x18,0xA6). ovf=1, count=4, and entry 0xA6 never appears. ovf persists until flush.
- Flush priority: with count=3, drive flush=1, ihit=1 and dec_pause=0 together. Next cycle count=0, out_valid=0, outputs 0, ovf=0. A push on the following cycle appears as head one cycle later.
- Reset mid-stream: with count=2, drive RST=1 and flush=0, ihit=1 in the same cycle. Next cycle all outputs are at their reset values.
